// File: rtl/sram_arb_pkg.sv
// Shared owner tags, FSM state encodings and default depth for the SRAM bus arbiter.
package sram_arb_pkg;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOCK_I = 2'd1;
  localparam logic [1:0] ST_LOCK_D = 2'd2;

  localparam int MAX_OUT_DEFAULT = 4;

endpackage

// File: rtl/arb_tag_fifo.sv
// 1-bit-wide owner-tag FIFO; a pop in the same cycle frees the slot for a push when full.
module arb_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     din,
  output logic                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbitrates inst/data SRAM-like requesters onto one memory port and routes in-order responses.
// Optional SRAM_ARB_RR_EN: round-robin between simultaneous requesters instead of data-first.
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = MAX_OUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wstrb,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                arb_err
);

  localparam int CW = $clog2(MAX_OUT) + 1;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          head_own;
  logic          have_cand;
  logic          cand_own;
  logic          room;
  logic          grant;
  logic          push;
  logic          pop;

`ifdef SRAM_ARB_RR_EN
  logic last_grant;
`endif

  // A locked owner keeps the port until its pending request is accepted.
  always_comb begin
    have_cand = 1'b0;
    cand_own  = OWN_INST;
    case (state)
      ST_LOCK_I: have_cand = inst_req;
      ST_LOCK_D: begin
        have_cand = data_req;
        cand_own  = OWN_DATA;
      end
      default: begin
        have_cand = inst_req || data_req;
`ifdef SRAM_ARB_RR_EN
        if (inst_req && data_req)
          cand_own = ~last_grant;
        else
          cand_own = data_req ? OWN_DATA : OWN_INST;
`else
        cand_own = data_req ? OWN_DATA : OWN_INST;
`endif
      end
    endcase
  end

  assign pop   = mem_data_ok && !empty && !rst;
  assign room  = !full || pop;
  assign grant = !rst && have_cand && room;
  assign push  = grant && mem_addr_ok;

  assign mem_req   = grant;
  assign mem_wr    = (cand_own == OWN_DATA) ? data_wr    : inst_wr;
  assign mem_size  = (cand_own == OWN_DATA) ? data_size  : inst_size;
  assign mem_addr  = (cand_own == OWN_DATA) ? data_addr  : inst_addr;
  assign mem_wdata = (cand_own == OWN_DATA) ? data_wdata : inst_wdata;
  assign mem_wstrb = (cand_own == OWN_DATA) ? data_wstrb : inst_wstrb;

  assign inst_addr_ok = push && (cand_own == OWN_INST);
  assign data_addr_ok = push && (cand_own == OWN_DATA);
  assign inst_data_ok = pop && (head_own == OWN_INST);
  assign data_data_ok = pop && (head_own == OWN_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_comb begin
    state_nxt = state;
    if (grant) begin
      if (mem_addr_ok)
        state_nxt = ST_IDLE;
      else
        state_nxt = (cand_own == OWN_DATA) ? ST_LOCK_D : ST_LOCK_I;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      arb_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (mem_data_ok && (count == '0))
        arb_err <= 1'b1;
    end
  end

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= OWN_INST;
    else if (push)
      last_grant <= cand_own;
  end
`endif

  arb_tag_fifo #(
    .DEPTH(MAX_OUT)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (cand_own),
    .dout  (head_own),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter (default build, fixed data-over-inst priority).
module tb_sram_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req, inst_wr, data_req, data_wr;
  logic [1:0]    inst_size, data_size;
  logic [AW-1:0] inst_addr, data_addr;
  logic [DW-1:0] inst_wdata, data_wdata;
  logic [DW/8-1:0] inst_wstrb, data_wstrb;
  logic          inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [DW-1:0] inst_rdata, data_rdata;
  logic          mem_req, mem_wr;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic          mem_addr_ok, mem_data_ok;
  logic [DW-1:0] mem_rdata;
  logic          arb_err;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_wstrb(inst_wstrb), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .arb_err(arb_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of outstanding owner tags (0=inst, 1=data), pending lock, sticky error.
  bit mq[$];
  bit lock_v   = 1'b0;
  bit lock_own = 1'b0;
  bit m_err    = 1'b0;
  bit acc_i, acc_d;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs for the current inputs, then advance the model over the edge.
  task automatic applyStimulus();
    bit has_c, c_own, room, exp_req, dok_v, dok_own;
    #2;
    room  = (mq.size() < MO) || (mem_data_ok && mq.size() > 0);
    has_c = 1'b0;
    c_own = 1'b0;
    if (lock_v) begin
      has_c = lock_own ? data_req : inst_req;
      c_own = lock_own;
    end else if (data_req) begin
      has_c = 1'b1;
      c_own = 1'b1;
    end else if (inst_req) begin
      has_c = 1'b1;
    end
    exp_req = !rst && has_c && room;
    dok_v   = !rst && mem_data_ok && (mq.size() > 0);
    dok_own = dok_v ? mq[0] : 1'b0;
    acc_i   = exp_req && !c_own && mem_addr_ok;
    acc_d   = exp_req && c_own && mem_addr_ok;

    checkOutput("mem_req", mem_req, exp_req);
    checkOutput("inst_addr_ok", inst_addr_ok, acc_i);
    checkOutput("data_addr_ok", data_addr_ok, acc_d);
    if (exp_req) begin
      checkOutput("mem_addr", mem_addr, c_own ? data_addr : inst_addr);
      checkOutput("mem_wr", mem_wr, c_own ? data_wr : inst_wr);
      checkOutput("mem_wdata", mem_wdata, c_own ? data_wdata : inst_wdata);
    end
    checkOutput("inst_data_ok", inst_data_ok, dok_v && !dok_own);
    checkOutput("data_data_ok", data_data_ok, dok_v && dok_own);
    if (dok_v)
      checkOutput("rdata", dok_own ? data_rdata : inst_rdata, mem_rdata);
    checkOutput("arb_err", arb_err, m_err);

    @(posedge clk);
    if (rst) begin
      mq.delete();
      lock_v = 1'b0;
      m_err  = 1'b0;
    end else begin
      if (mem_data_ok) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else m_err = 1'b1;
      end
      if (exp_req) begin
        if (mem_addr_ok) begin
          mq.push_back(c_own);
          lock_v = 1'b0;
        end else begin
          lock_v   = 1'b1;
          lock_own = c_own;
        end
      end
    end
    #1;
  endtask

  task automatic idleInputs();
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0; rst = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < MO + 1 && mq.size() > 0; k++) begin
      idleInputs();
      mem_data_ok = 1;
      mem_rdata   = $urandom;
      applyStimulus();
    end
  endtask

  bit ip, dp;

  initial begin
    rst = 1; inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    inst_wr = 0; inst_size = 2'd2; inst_addr = 32'h1000; inst_wdata = '0; inst_wstrb = '0;
    data_wr = 0; data_size = 2'd2; data_addr = 32'h2000; data_wdata = '0; data_wstrb = '0;
    mem_rdata = '0;
    @(posedge clk);
    #1;
    $display("[TB] reset checks");
    inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    #1;
    checkOutput("rst_mem_req", mem_req, 1'b0);
    checkOutput("rst_data_ok", inst_data_ok | data_data_ok, 1'b0);
    applyStimulus();

    $display("[TB] test 1: simultaneous requests");
    idleInputs();
    inst_req = 1; data_req = 1; mem_addr_ok = 1; data_wr = 1; data_wdata = 32'hDEAD_BEEF;
    #1;
    checkOutput("t1_data_addr_ok", data_addr_ok, 1'b1);
    checkOutput("t1_inst_addr_ok", inst_addr_ok, 1'b0);
    applyStimulus();
    data_req = 0;
    applyStimulus();
    drain();

    $display("[TB] test 2: lock on inst");
    idleInputs();
    inst_req = 1; inst_addr = 32'h1100;
    applyStimulus();
    data_req = 1; data_addr = 32'h2200;
    #1;
    checkOutput("t2_lock_addr", mem_addr, 32'h1100);
    applyStimulus();
    applyStimulus();
    mem_addr_ok = 1;
    #1;
    checkOutput("t2_inst_accept", inst_addr_ok, 1'b1);
    applyStimulus();
    inst_req = 0;
    #1;
    checkOutput("t2_data_after", data_addr_ok, 1'b1);
    applyStimulus();
    data_req = 0;
    drain();

    $display("[TB] test 3: full FIFO");
    idleInputs();
    inst_req = 1; mem_addr_ok = 1;
    for (int k = 0; k < MO; k++) begin
      inst_addr = 32'h3000 + 32'(k * 4);
      applyStimulus();
    end
    #1;
    checkOutput("t3_full_block", mem_req, 1'b0);
    applyStimulus();
    mem_data_ok = 1; mem_rdata = 32'h55;
    #1;
    checkOutput("t3_pop_push", mem_req, 1'b1);
    applyStimulus();
    mem_data_ok = 0;
    #1;
    checkOutput("t3_still_full", mem_req, 1'b0);
    applyStimulus();
    drain();

    $display("[TB] test 4: response routing");
    idleInputs();
    mem_addr_ok = 1;
    inst_req = 1; applyStimulus(); inst_req = 0;
    data_req = 1; applyStimulus(); data_req = 0;
    inst_req = 1; applyStimulus(); inst_req = 0;
    mem_addr_ok = 0; mem_data_ok = 1;
    mem_rdata = 32'hA;
    #1;
    checkOutput("t4_a_inst", {inst_data_ok, data_data_ok, inst_rdata}, {2'b10, 32'hA});
    applyStimulus();
    mem_rdata = 32'hB;
    #1;
    checkOutput("t4_b_data", {inst_data_ok, data_data_ok, data_rdata}, {2'b01, 32'hB});
    applyStimulus();
    mem_rdata = 32'hC;
    #1;
    checkOutput("t4_c_inst", {inst_data_ok, data_data_ok, inst_rdata}, {2'b10, 32'hC});
    applyStimulus();

    $display("[TB] random traffic");
    idleInputs();
    ip = 0; dp = 0;
    for (int n = 0; n < 400; n++) begin
      if (!ip && $urandom_range(99) < 40) begin
        ip = 1; inst_addr = $urandom; inst_wr = 1'($urandom); inst_wdata = $urandom;
      end
      if (!dp && $urandom_range(99) < 40) begin
        dp = 1; data_addr = $urandom; data_wr = 1'($urandom); data_wdata = $urandom;
      end
      inst_req    = ip;
      data_req    = dp;
      mem_addr_ok = ($urandom_range(99) < 60);
      mem_data_ok = (mq.size() > 0) && ($urandom_range(1) == 1);
      mem_rdata   = $urandom;
      applyStimulus();
      if (acc_i) ip = 0;
      if (acc_d) dp = 0;
    end
    idleInputs();
    applyStimulus();

    $display("[TB] test 5: reset mid-transaction");
    drain();
    idleInputs();
    mem_addr_ok = 1;
    inst_req = 1; applyStimulus(); inst_req = 0;
    data_req = 1; applyStimulus(); data_req = 0;
    idleInputs();
    rst = 1;
    applyStimulus();
    rst = 0; mem_data_ok = 1; mem_rdata = 32'h77;
    #1;
    checkOutput("t5_no_data_ok", inst_data_ok | data_data_ok, 1'b0);
    applyStimulus();
    mem_data_ok = 0;
    #1;
    checkOutput("t5_arb_err", arb_err, 1'b1);
    applyStimulus();
    applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
